// File: rtl/multi_ce_pkg.sv
// Shared types and defaults for the multi-channel fractional clock-enable generator.
package multi_ce_pkg;

  localparam int DEF_ACC_W       = 24;
  localparam int DEF_LOCK_CYCLES = 16;

  typedef enum logic [1:0] {SETTLE, LOCKED, APPLY} state_t;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ce_accum.sv
// One fractional-rate channel: phase accumulator, ratio registers and registered strobe.
module ce_accum #(
  parameter int ACC_W = 24
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [ACC_W-1:0] num_in,
  input  logic [ACC_W-1:0] den_in,
  input  logic [ACC_W-1:0] phase,
  output logic             ce
);

  localparam logic [ACC_W-1:0] ONE = 1;

  logic [ACC_W-1:0] acc, num, den;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] diff, num_clamp, den_next, phase_clamp;
  logic             hit;

  always_comb begin
    sum  = {1'b0, acc} + {1'b0, num};
    hit  = (den != '0) && (sum >= {1'b0, den});
    // The true difference fits in ACC_W bits because acc < den and num <= den.
    diff = sum[ACC_W-1:0] - den;
    num_clamp   = (num_in > den_in) ? den_in : num_in;
    den_next    = load ? den_in : den;
    phase_clamp = (den_next == '0) ? '0 :
                  (phase >= den_next) ? den_next - ONE : phase;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      num <= '0;
      den <= '0;
      ce  <= 1'b0;
    end else begin
      if (load) begin
        num <= num_clamp;
        den <= den_in;
      end
      // The strobe on the realign edge still follows the ratio in force.
      ce <= hit;
      if (clear)          acc <= phase_clamp;
      else if (den == '0) acc <= '0;
      else if (hit)       acc <= diff;
      else                acc <= sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/multi_ce_gen.sv
// N-channel fractional clock-enable generator with runtime ratio config and lock flag.
// Optional MULTI_CE_PHASE_EN adds cfg_phase, a per-write initial phase for the target channel.
module multi_ce_gen
  import multi_ce_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic                    refclk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [ch_w(NUM_CH)-1:0] cfg_ch,
  input  logic [ACC_W-1:0]        cfg_num,
  input  logic [ACC_W-1:0]        cfg_den,
`ifdef MULTI_CE_PHASE_EN
  input  logic [ACC_W-1:0]        cfg_phase,
`endif
  output logic [NUM_CH-1:0]       ce_out,
  output logic                    locked
);

  localparam int CH_W  = ch_w(NUM_CH);
  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = LOCK_CYCLES;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;

  state_t           state, state_nxt, ret_state;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             locked_nxt, accept, hit_ch, apply_go;

  logic [CH_W-1:0]  pend_ch;
  logic [ACC_W-1:0] pend_num, pend_den, phase_src;
  logic             pend_hit;

  assign accept = cfg_valid && cfg_ready;
  assign hit_ch = int'(cfg_ch) < NUM_CH;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= SETTLE;
      cnt    <= CNT_INIT;
      locked <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      locked <= locked_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    locked_nxt = locked;
    cfg_ready  = 1'b1;
    apply_go   = 1'b0;
    case (state)
      SETTLE: begin
        if (accept) begin
          state_nxt = APPLY;
          if (hit_ch) locked_nxt = 1'b0;
        end else if (cnt == CNT_ONE) begin
          state_nxt  = LOCKED;
          locked_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      LOCKED: begin
        if (accept) begin
          state_nxt = APPLY;
          if (hit_ch) locked_nxt = 1'b0;
        end
      end
      APPLY: begin
        cfg_ready = 1'b0;
        // An out-of-range write only costs the one-cycle stall.
        if (pend_hit) begin
          apply_go  = 1'b1;
          state_nxt = SETTLE;
          cnt_nxt   = CNT_INIT;
        end else begin
          state_nxt = ret_state;
        end
      end
      default: state_nxt = SETTLE;
    endcase
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pend_ch   <= '0;
      pend_num  <= '0;
      pend_den  <= '0;
      pend_hit  <= 1'b0;
      ret_state <= SETTLE;
    end else if (accept) begin
      pend_ch   <= cfg_ch;
      pend_num  <= cfg_num;
      pend_den  <= cfg_den;
      pend_hit  <= hit_ch;
      ret_state <= state;
    end
  end

`ifdef MULTI_CE_PHASE_EN
  logic [ACC_W-1:0] pend_phase;
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)      pend_phase <= '0;
    else if (accept) pend_phase <= cfg_phase;
  end
  assign phase_src = pend_phase;
`else
  assign phase_src = '0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic load;
    assign load = apply_go && (pend_ch == CH_W'(i));
    ce_accum #(.ACC_W(ACC_W)) u_ch (
      .refclk (refclk),
      .rst_n  (rst_n),
      .load   (load),
      .clear  (apply_go),
      .num_in (pend_num),
      .den_in (pend_den),
      .phase  (load ? phase_src : '0),
      .ce     (ce_out[i])
    );
  end

endmodule
